// File: rtl/shifter_pkg.sv
// Shared definitions for the 4-bit shifter family and its serial deserializer.
// Provides the default word width, the direction encoding and the deserializer
// FSM state type.
package shifter_pkg;

  localparam int SHIFT_W = 4;

  localparam logic DIR_LEFT  = 1'b0;  // MSB-first stream
  localparam logic DIR_RIGHT = 1'b1;  // LSB-first stream

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } deser_state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Accepted-bit counter for the deserializer. Counts up to TERM bits per word,
// strobes done combinationally on the bit that completes the word, and
// returns to zero on completion or on flush.
module shift_bit_counter #(
  parameter int TERM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int CW = $clog2(TERM + 1);
  localparam logic [CW-1:0] LAST = CW'(TERM - 1);

  logic [CW-1:0] cnt;

  assign done = inc && (cnt == LAST);

  // Bit count: flush and word completion both restart the count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer, receive side of the left/right shifter.
// Rebuilds WIDTH-bit words from a serial stream, MSB-first (d=0) or LSB-first
// (d=1), with the direction latched on each word's first bit.
// Optional build macro SHIFT_DESER_PARITY_EN: each word carries a trailing
// even-parity bit and a perr output flags a parity mismatch alongside o.
module shift_deserializer
  import shifter_pkg::*;
#(
  parameter int WIDTH = SHIFT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             d,
  input  logic             flush,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready
`ifdef SHIFT_DESER_PARITY_EN
  ,
  output logic             perr
`endif
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int TERM = WIDTH + 1;
`else
  localparam int TERM = WIDTH;
`endif

  deser_state_t     state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] word;
  logic             dir_q;
  logic             dir_eff;
  logic             accept;
  logic             take;
  logic             word_done;
  logic             out_free;
  logic             shift_en;

  // In STALL the held word blocks further input; no path from o_ready
  assign sin_ready = (state != STALL);
  assign accept    = sin_valid && sin_ready;
  // A flush in the same cycle drops the incoming bit
  assign take      = accept && !flush;
  assign out_free  = !o_valid || o_ready;
  // The first bit of a word uses the live d; later bits use the latched one
  assign dir_eff   = (state == IDLE) ? d : dir_q;
  assign sr_next   = dir_eff ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};

`ifdef SHIFT_DESER_PARITY_EN
  logic word_perr;
  logic perr_hold;

  // The parity bit closes the word but is never shifted into sr
  assign shift_en  = take && !word_done;
  assign word      = sr;
  assign word_perr = ^{sr, sin};
`else
  assign shift_en  = take;
  assign word      = sr_next;
`endif

  shift_bit_counter #(
    .TERM (TERM)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take),
    .clr   (flush),
    .done  (word_done)
  );

  // FSM, shift register, latched direction and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      dir_q   <= DIR_LEFT;
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
      if (flush) begin
        sr    <= '0;
        state <= IDLE;
      end else begin
        if (shift_en) begin
          sr <= sr_next;
        end
        if (take && (state == IDLE)) begin
          dir_q <= d;
        end
        case (state)
          IDLE, SHIFT: begin
            if (word_done) begin
              if (out_free) begin
                o       <= word;
                o_valid <= 1'b1;
                state   <= IDLE;
              end else begin
                state   <= STALL;
              end
            end else if (take) begin
              state <= SHIFT;
            end
          end
          STALL: begin
            if (o_valid && o_ready) begin
              o       <= sr;
              o_valid <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  // Parity flag travels with the word: loaded with o, parked while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr      <= 1'b0;
      perr_hold <= 1'b0;
    end else if (!flush) begin
      if (word_done) begin
        if (out_free) begin
          perr <= word_perr;
        end else begin
          perr_hold <= word_perr;
        end
      end else if ((state == STALL) && o_valid && o_ready) begin
        perr <= perr_hold;
      end
    end
  end
`endif

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's 4-bit left/right shifter.
- Collects a serial bit stream, one bit per accepted cycle, and rebuilds parallel WIDTH-bit words.
- Direction input d picks the order: d=0 means MSB-first (left-shift stream), d=1 means LSB-first (right-shift stream).
- Sits between a serial link and the parallel datapath. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sin  input  1  serial data bit
- sin_valid  input  1  sin is valid this cycle
- sin_ready  output  1  block accepts sin this cycle
- d  input  1  direction for the next word (0 = MSB-first, 1 = LSB-first); sampled on a word's first bit
- flush  input  1  synchronous discard of any partial or held word
- o  output  WIDTH  reassembled word
- o_valid  output  1  o holds a word
- o_ready  input  1  consumer takes o this cycle

Behaviour:
- Reset (async assert, sync-safe deassert) clears:
  - shift reg sr, bit count cnt, latched direction dir_q, o, o_valid; state = IDLE.
  - sin_ready = 1 once out of reset.
- Bit accept = sin_valid && sin_ready.
- States:
  - IDLE (cnt=0): an accepted bit latches dir_q=d, shifts the bit in, sets cnt=1 and moves to SHIFT.
  - SHIFT: each accepted bit shifts in and increments cnt.
  - On the bit that makes cnt==WIDTH (word complete):
    - If output is free (!o_valid || o_ready): o <= completed word, o_valid <= 1, cnt <= 0, go to IDLE.
    - Otherwise: go to STALL holding the word in sr.
  - STALL: sin_ready=0. When o_valid && o_ready: o <= sr, o_valid stays 1, go to IDLE.
- Shift rules:
  - dir_q=0: sr <= {sr[WIDTH-2:0], sin}, so the first bit lands in the MSB.
  - dir_q=1: sr <= {sin, sr[WIDTH-1:1]}, so the first bit lands in the LSB.
- Changes on d mid-word are ignored.
- sin_ready = (state != STALL). It is combinational from state only, with no path from o_ready.
- Latency: o_valid rises the cycle after the last bit is accepted. Back-to-back words stream with no bubble when o_ready=1.
- o_valid falls the cycle after o_ready && o_valid, unless a new word loads in that same cycle.
- o is stable while o_valid && !o_ready.
- flush:
  - Forces cnt=0, sr=0, state IDLE.
  - Does not touch o or o_valid.
  - flush together with an accepted bit: flush wins and the bit is dropped.
  - flush in STALL: the held word is discarded.
- Reset asserted mid-word: partial word lost; no o_valid pulse afterward.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit; completion occurs on bit WIDTH+1.
  - The parity bit is not shifted into sr.
  - Added output port perr (1 bit) is registered with o and valid while o_valid=1: perr=1 when XOR(data bits, parity bit) != 0.
  - Reset value of perr is 0. flush discards a pending parity bit.
- Not defined: perr port absent; WIDTH bits per word; behaviour exactly as above.

Decomposition:
- Shared package shifter_pkg holds:
  - default width constant SHIFT_W=4
  - direction constants DIR_LEFT=0, DIR_RIGHT=1
  - state encoding IDLE/SHIFT/STALL as 2-bit typedef deser_state_t
- One natural sub-module: shift_bit_counter.
  - Counts accepted bits; clear on flush or completion.
  - Terminal count = WIDTH, or WIDTH+1 with parity.
  - Drives the word-complete strobe.
- The top level keeps sr, dir_q, the output register and the FSM.

Test Plan:
- d=0, bits 1,0,1,1 on consecutive cycles, o_ready=1 -> o=4'hB with o_valid=1 one cycle after the 4th bit; single-cycle pulse.
- d=1, same bits 1,0,1,1 -> o=4'hD. Then toggle d after the 2nd bit of the next word 0,0,1,1 -> direction unchanged, o=4'hC.
- o_ready=0; send 4'hB then 1,1,1,1 (d=0) -> o holds 4'hB, state STALL, sin_ready=0. Raise o_ready -> next cycle o=4'hF, sin_ready=1.
- Send 1,1 then flush together with a 3rd valid bit -> bit dropped, cnt=0. Send 0,1,0,1 (d=0) -> o=4'h5.
- Assert rst_n=0 asynchronously after 2 bits -> o_valid=0, o=0, sin_ready=1 immediately. Next full word decodes correctly.
- With SHIFT_DESER_PARITY_EN:
  - d=0, 1,0,1,1 plus parity 1 -> o=4'hB, perr=0.
  - Same word with parity 0 -> perr=1.
